mux_arbiter4: RTL and testbench

Round-robin arbiter and sequencer for a shared WIDTH-bit 4:1 multiplexer port. Four requesters present data plus a request. The block grants one requester at a time, drives the mux select, and presents the selected data downstream under a valid/ready handshake. It bounds each tenure to MAX_BURST transfers so that no requester can starve the others. It sits in front of any shared resource in the pipelined CPU that is fed through a 4:1 mux, for example a shared write-back or memory port.

---
 rtl/arb_pkg.sv | 32 +++
 rtl/mux4_n.sv | 26 ++
 rtl/mux_arbiter4.sv | 121 ++++++++++++
 tb/tb_mux_arbiter4.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way mux arbiter.
// Holds the FSM state type and the round-robin search.
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Search from last+1 around to last; returns {found, idx}.
  function automatic logic [2:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [1:0]         last
  );
    logic       found;
    logic [1:0] idx;
    logic [1:0] j;
    found = 1'b0;
    idx   = last;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = last + 2'(i);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mux4_n.sv
// WIDTH-bit 4:1 multiplexer built from per-bit slices.
// Feeds the arbiter's shared output port.
module mux4_n #(
  parameter int WIDTH = 64
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    // One 4:1 slice per data bit.
    always_comb begin
      unique case (sel)
        2'd0:    out[b] = in0[b];
        2'd1:    out[b] = in1[b];
        2'd2:    out[b] = in2[b];
        default: out[b] = in3[b];
      endcase
    end
  end

endmodule

// File: rtl/mux_arbiter4.sv
// Round-robin arbiter fronting a shared 4:1 mux port.
// Bounds each tenure to MAX_BURST accepted transfers.
module mux_arbiter4
  import arb_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int MAX_BURST = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   din,
  input  logic                            out_ready,
  output logic [NUM_REQ-1:0]              grant,
  output logic [1:0]                      sel,
  output logic                            out_valid,
  output logic [WIDTH-1:0]                dout,
  output logic [NUM_REQ-1:0]              ack
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  state_t        r_state;
  logic [1:0]    r_sel;
  logic [1:0]    r_last;
  logic [CW-1:0] r_cnt;

  state_t        w_state_nxt;
  logic [1:0]    w_sel_nxt;
  logic [1:0]    w_last_nxt;
  logic [CW-1:0] w_cnt_nxt;

  logic [2:0]    w_pick;
  logic          w_found;
  logic [1:0]    w_idx;
  logic          w_own_req;
  logic          w_xfer;
  logic          w_release;

  assign w_pick    = rr_pick(req, r_last);
  assign w_found   = w_pick[2];
  assign w_idx     = w_pick[1:0];
  assign w_own_req = req[r_sel];
  assign w_xfer    = (r_state == OWN) && w_own_req && out_ready;
  assign w_release = !w_own_req ||
                     (w_xfer && (r_cnt == LAST_CNT));

  // State register: async reset drops any tenure at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= 2'd0;
      r_last  <= 2'd3;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: grant, re-pick on release, count transfers.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = OWN;
          w_sel_nxt   = w_idx;
          w_last_nxt  = w_idx;
          w_cnt_nxt   = '0;
        end
      end
      OWN: begin
        if (w_release) begin
          if (w_found) begin
            w_sel_nxt  = w_idx;
            w_last_nxt = w_idx;
            w_cnt_nxt  = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs: one-hot grant, valid and ack follow the owner.
  always_comb begin
    grant     = '0;
    out_valid = 1'b0;
    ack       = '0;
    if (r_state == OWN) begin
      grant[r_sel] = 1'b1;
      out_valid    = w_own_req;
      ack[r_sel]   = w_xfer;
    end
  end

  assign sel = r_sel;

  mux4_n #(
    .WIDTH(WIDTH)
  ) u_mux (
    .out(dout),
    .in0(din[0]),
    .in1(din[1]),
    .in2(din[2]),
    .in3(din[3]),
    .sel(r_sel)
  );

endmodule

// File: tb/tb_mux_arbiter4.sv
// Scoreboard bench for mux_arbiter4.
// Expected per-cycle outputs come from a behavioural model.
module tb_mux_arbiter4;

  localparam int W  = 64;
  localparam int MB = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [3:0]          req = '0;
  logic [3:0][W-1:0]   din;
  logic                out_ready = 1'b0;
  logic [3:0]          grant;
  logic [1:0]          sel;
  logic                out_valid;
  logic [W-1:0]        dout;
  logic [3:0]          ack;

  mux_arbiter4 #(
    .WIDTH(W),
    .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .din(din),
    .out_ready(out_ready),
    .grant(grant),
    .sel(sel),
    .out_valid(out_valid),
    .dout(dout),
    .ack(ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   g;
    logic         v;
    logic [3:0]   a;
    logic [1:0]   s;
    logic [W-1:0] d;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  bit   m_own;
  int   m_sel;
  int   m_last;
  int   m_cnt;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %h want %h at %0t",
               tag, got, want, $time);
    end
  endtask

  function automatic void m_reset();
    m_own  = 1'b0;
    m_sel  = 0;
    m_last = 3;
    m_cnt  = 0;
  endfunction

  function automatic int m_pick();
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (m_last + k) % 4;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  function automatic exp_t m_out();
    exp_t e;
    e.g = 4'b0000;
    e.v = 1'b0;
    e.a = 4'b0000;
    e.s = 2'(m_sel);
    e.d = din[m_sel];
    if (m_own) begin
      e.g = 4'b0001 << m_sel;
      e.v = req[m_sel];
      if (e.v && out_ready) e.a = 4'b0001 << m_sel;
    end
    return e;
  endfunction

  // Advance the model across one rising edge with current inputs.
  function automatic void m_step();
    int  p;
    bit  xfer;
    bit  rel;
    p = m_pick();
    if (!m_own) begin
      if (p >= 0) begin
        m_own = 1'b1; m_sel = p; m_last = p; m_cnt = 0;
      end
    end else begin
      xfer = req[m_sel] && out_ready;
      rel  = !req[m_sel] || (xfer && m_cnt == MB - 1);
      if (rel) begin
        if (p >= 0) begin
          m_sel = p; m_last = p; m_cnt = 0;
        end else begin
          m_own = 1'b0;
        end
      end else if (xfer) begin
        m_cnt++;
      end
    end
  endfunction

  task automatic step(input logic [3:0] r, input logic rdy,
                      output logic [3:0] g_obs,
                      output logic [3:0] a_obs);
    exp_t e;
    @(negedge clk);
    req = r;
    out_ready = rdy;
    q.push_back(m_out());
    #2;
    e = q.pop_front();
    chk("grant", 64'(grant), 64'(e.g));
    chk("out_valid", 64'(out_valid), 64'(e.v));
    chk("ack", 64'(ack), 64'(e.a));
    chk("sel", 64'(sel), 64'(e.s));
    if (e.v) chk("dout", dout, e.d);
    g_obs = grant;
    a_obs = ack;
    m_step();
  endtask

  task automatic do_reset(input logic [3:0] r_after);
    @(negedge clk);
    reset = 1'b1;
    req = 4'b1111;
    #1;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    req = r_after;
    out_ready = 1'b0;
    m_reset();
    m_step();
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] a;
    logic [3:0] exp_g;
    int         nack;
    logic [W-1:0] d_hold;

    for (int k = 0; k < 4; k++) din[k] = {16'hA000 + 16'(k), 48'h1234_5678_9ABC};
    m_reset();

    // Reset held with all requests while ready toggles.
    req = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      out_ready = ~out_ready;
      #2;
      chk("rst_grant", 64'(grant), 64'h0);
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_ack", 64'(ack), 64'h0);
      chk("rst_sel", 64'(sel), 64'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    m_step();
    step(4'b1111, 1'b1, g, a);
    chk("first_grant", 64'(g), 64'h1);

    // Single requester sustained: ack every cycle once granted.
    do_reset(4'b0000);
    nack = 0;
    for (int c = 0; c < 10; c++) begin
      step(4'b0100, 1'b1, g, a);
      if (a[2]) nack++;
      if (c > 0) chk("single_grant", 64'(g), 64'h4);
    end
    chk("single_acks", 64'(nack), 64'd9);

    // All requesting: four-transfer tenures in index order.
    do_reset(4'b0000);
    for (int c = 0; c < 21; c++) begin
      step(4'b1111, 1'b1, g, a);
      exp_g = (c == 0) ? 4'b0000 : 4'(4'b0001 << (((c - 1) / 4) % 4));
      chk("rr_grant", 64'(g), 64'(exp_g));
      chk("rr_ack", 64'(a), 64'(exp_g));
    end

    // Backpressure on owner 1 after one transfer.
    do_reset(4'b0000);
    step(4'b0010, 1'b1, g, a);
    step(4'b0010, 1'b1, g, a);
    chk("bp_first_ack", 64'(a), 64'h2);
    d_hold = din[1];
    for (int c = 0; c < 3; c++) begin
      step(4'b0010, 1'b0, g, a);
      chk("bp_no_ack", 64'(a), 64'h0);
      chk("bp_dout", dout, d_hold);
    end
    nack = 0;
    for (int c = 0; c < 3; c++) begin
      step(4'b0010, 1'b1, g, a);
      if (a[1]) nack++;
    end
    chk("bp_resume_acks", 64'(nack), 64'd3);
    step(4'b0000, 1'b1, g, a);
    chk("bp_regrant", 64'(g), 64'h2);

    // Early drop by owner 0 hands over to requester 3.
    do_reset(4'b0000);
    step(4'b1001, 1'b1, g, a);
    step(4'b1001, 1'b1, g, a);
    step(4'b1001, 1'b1, g, a);
    step(4'b1000, 1'b1, g, a);
    chk("drop_owner", 64'(g), 64'h1);
    step(4'b1000, 1'b1, g, a);
    chk("drop_handover", 64'(g), 64'h8);
    chk("drop_ack", 64'(a), 64'h8);

    // Asynchronous reset between edges while 1 owns.
    do_reset(4'b0000);
    step(4'b0010, 1'b1, g, a);
    @(negedge clk);
    req = 4'b0010;
    out_ready = 1'b1;
    #2;
    chk("mid_grant", 64'(grant), 64'h2);
    reset = 1'b1;
    #1;
    chk("async_grant", 64'(grant), 64'h0);
    chk("async_valid", 64'(out_valid), 64'h0);
    chk("async_ack", 64'(ack), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    req = 4'b1010;
    m_reset();
    m_step();
    step(4'b1010, 1'b1, g, a);
    chk("post_rst_grant", 64'(g), 64'h2);

    // Random traffic against the model.
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 7) == 0) din[k] = {$urandom, $urandom};
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), g, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
